// File: rtl/inta_cascade_responder.sv
// Purpose: 8259-style INTA cycle responder. Tracks the two-pulse INTA
//          handshake, drives the cascade address as a master, decides
//          whether this device owns the vector byte, and pulses isr_set
//          on the first acknowledge.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   SP, SNGL, ICW3        master/slave, single/cascade, cascade config
//   vector_base           ICW2 T7..T3
//   int_req, int_level    resolved pending request and its level
//   inta_n                CPU acknowledge strobe (active-low, clk-synchronous)
//   cas_i                 CAS bus as seen by this device
//   cas_o, cas_oe         CAS drive value and enable (master only)
//   data_o, data_oe       vector byte and data bus enable
//   isr_set, ack_level    one-cycle ISR set pulse and acknowledged level
module inta_cascade_responder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SP,
  input  logic       SNGL,
  input  logic [7:0] ICW3,
  input  logic [4:0] vector_base,
  input  logic       int_req,
  input  logic [2:0] int_level,
  input  logic       inta_n,
  input  logic [2:0] cas_i,
  output logic [2:0] cas_o,
  output logic       cas_oe,
  output logic [7:0] data_o,
  output logic       data_oe,
  output logic       isr_set,
  output logic [2:0] ack_level
);

  localparam int unsigned LVL_W = 3;
  localparam int unsigned VEC_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK1 = 2'd1,
    S_GAP  = 2'd2,
    S_ACK2 = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic               r_inta_prev;
  logic               r_valid;
  logic [LVL_W-1:0]   r_lvl;
  logic [LVL_W-1:0]   r_cas;
  logic               r_ack1_first;

  logic [LVL_W-1:0]   r_cas_o;
  logic               r_cas_oe;
  logic [VEC_W-1:0]   r_data_o;
  logic               r_data_oe;
  logic               r_isr_set;
  logic [LVL_W-1:0]   r_ack_level;

  logic               w_fall;
  logic               w_rise;
  logic               w_enter_ack1;
  logic               w_casc;
  logic               w_sel;
  logic               w_owner;
  logic               w_active;

  logic [LVL_W-1:0]   w_cas_o_nxt;
  logic               w_cas_oe_nxt;
  logic [VEC_W-1:0]   w_data_o_nxt;
  logic               w_data_oe_nxt;
  logic               w_isr_set_nxt;
  logic [LVL_W-1:0]   w_ack_level_nxt;

  // Edge detection against the previous sampled strobe.
  assign w_fall = r_inta_prev & ~inta_n;
  assign w_rise = ~r_inta_prev & inta_n;

  // Ownership decode from the values frozen at the first acknowledge.
  assign w_casc   = ~SNGL & SP & r_valid & ICW3[r_lvl];
  assign w_sel    = ~SNGL & ~SP & (r_cas == ICW3[2:0]);
  assign w_owner  = SNGL | (SP & ~w_casc) | w_sel;
  assign w_active = (r_state != S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_enter_ack1    = 1'b0;
    w_cas_oe_nxt    = 1'b0;
    w_cas_o_nxt     = '0;
    w_data_oe_nxt   = 1'b0;
    w_data_o_nxt    = '0;
    w_isr_set_nxt   = 1'b0;
    w_ack_level_nxt = '0;

    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nxt  = S_ACK1;
          w_enter_ack1 = 1'b1;
        end
      end
      S_ACK1:  if (w_rise) w_state_nxt = S_GAP;
      S_GAP:   if (w_fall) w_state_nxt = S_ACK2;
      S_ACK2:  if (w_rise) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_active && w_casc) begin
      w_cas_oe_nxt = 1'b1;
      w_cas_o_nxt  = r_lvl;
    end

    if (w_active) begin
      w_ack_level_nxt = r_lvl;
    end

    // Only the first cycle after entering ACK1 may set the ISR.
    w_isr_set_nxt = r_ack1_first & r_valid & (SNGL | SP | w_sel);

    // No valid request at the first acknowledge answers as spurious IR7.
    if ((r_state == S_ACK2) && w_owner) begin
      w_data_oe_nxt = 1'b1;
      w_data_o_nxt  = {vector_base, (r_valid ? r_lvl : 3'b111)};
    end
  end

  // Strobe history and per-sequence capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inta_prev  <= 1'b1;
      r_valid      <= 1'b0;
      r_lvl        <= '0;
      r_cas        <= '0;
      r_ack1_first <= 1'b0;
    end else begin
      r_inta_prev  <= inta_n;
      r_ack1_first <= w_enter_ack1;
      if (w_enter_ack1) begin
        r_valid <= int_req;
        r_lvl   <= int_level;
        r_cas   <= cas_i;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cas_o     <= '0;
      r_cas_oe    <= 1'b0;
      r_data_o    <= '0;
      r_data_oe   <= 1'b0;
      r_isr_set   <= 1'b0;
      r_ack_level <= '0;
    end else begin
      r_cas_o     <= w_cas_o_nxt;
      r_cas_oe    <= w_cas_oe_nxt;
      r_data_o    <= w_data_o_nxt;
      r_data_oe   <= w_data_oe_nxt;
      r_isr_set   <= w_isr_set_nxt;
      r_ack_level <= w_ack_level_nxt;
    end
  end

  assign cas_o     = r_cas_o;
  assign cas_oe    = r_cas_oe;
  assign data_o    = r_data_o;
  assign data_oe   = r_data_oe;
  assign isr_set   = r_isr_set;
  assign ack_level = r_ack_level;

endmodule

// File: tb/tb_inta_cascade_responder.sv
// Purpose: directed table-driven bench for inta_cascade_responder plus
//          hand-written sequences for one-cycle pulses, mid-sequence input
//          changes and asynchronous reset during ACK2.
module tb_inta_cascade_responder;

  logic       clk;
  logic       rst_n;
  logic       SP;
  logic       SNGL;
  logic [7:0] ICW3;
  logic [4:0] vector_base;
  logic       int_req;
  logic [2:0] int_level;
  logic       inta_n;
  logic [2:0] cas_i;
  logic [2:0] cas_o;
  logic       cas_oe;
  logic [7:0] data_o;
  logic       data_oe;
  logic       isr_set;
  logic [2:0] ack_level;

  int n_cmp;
  int n_bad;

  inta_cascade_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .SP          (SP),
    .SNGL        (SNGL),
    .ICW3        (ICW3),
    .vector_base (vector_base),
    .int_req     (int_req),
    .int_level   (int_level),
    .inta_n      (inta_n),
    .cas_i       (cas_i),
    .cas_o       (cas_o),
    .cas_oe      (cas_oe),
    .data_o      (data_o),
    .data_oe     (data_oe),
    .isr_set     (isr_set),
    .ack_level   (ack_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sp;
    logic       sngl;
    logic [7:0] icw3;
    logic [4:0] vb;
    logic       req;
    logic [2:0] lvl;
    logic [2:0] cas;
    logic       isr;
    logic [2:0] ack;
    logic [2:0] caso;
    logic       casoe;
    logic [7:0] dat;
    logic       doe;
  } vec_t;

  localparam int unsigned NVEC = 9;
  vec_t vecs [NVEC];

  // Observed outputs as {cas_o, cas_oe, data_o, data_oe, isr_set, ack_level}.
  function automatic logic [16:0] pk(input logic [2:0] co, input logic coe,
                                     input logic [7:0] d, input logic doe,
                                     input logic isr, input logic [2:0] ack);
    return {co, coe, d, doe, isr, ack};
  endfunction

  task automatic chk(input string nm, input logic [16:0] exp);
    logic [16:0] got;
    got = pk(cas_o, cas_oe, data_o, data_oe, isr_set, ack_level);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got{caso,oe,data,doe,isr,ack}=%h/%b/%h/%b/%b/%0d required=%h/%b/%h/%b/%b/%0d",
               nm, got[16:14], got[13], got[12:5], got[4], got[3], got[2:0],
               exp[16:14], exp[13], exp[12:5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  // Drive inta_n at the falling edge, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic v);
    @(negedge clk);
    inta_n = v;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input vec_t v);
    SP          = v.sp;
    SNGL        = v.sngl;
    ICW3        = v.icw3;
    vector_base = v.vb;
    int_req     = v.req;
    int_level   = v.lvl;
    cas_i       = v.cas;
  endtask

  // Standard sequence: inta_n = 1,1,0,0,1,1,0,0,1,1,1 (edges t=0..10).
  task automatic run_vec(input int idx, input vec_t v);
    logic       pin;
    logic [16:0] exp;
    @(negedge clk);
    set_cfg(v);
    for (int t = 0; t < 11; t++) begin
      pin = !(t == 2 || t == 3 || t == 6 || t == 7);
      cyc(pin);
      exp = '0;
      if (t >= 3 && t <= 8) begin
        exp[16:14] = v.caso;
        exp[13]    = v.casoe;
        exp[2:0]   = v.ack;
      end
      if (t == 3) exp[3] = v.isr;
      if (t == 7 || t == 8) begin
        exp[12:5] = v.dat;
        exp[4]    = v.doe;
      end
      chk($sformatf("vec%0d_t%0d", idx, t), exp);
      // Inputs after the first acknowledge must be ignored.
      if (t == 3) begin
        int_req   = ~v.req;
        int_level = ~v.lvl;
        cas_i     = ~v.cas;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    //          sp    sngl  icw3   vb        req   lvl   cas   isr   ack   caso  oe    dat    doe
    vecs[0] = '{1'b1, 1'b1, 8'h00, 5'b01000, 1'b1, 3'd3, 3'd0, 1'b1, 3'd3, 3'd0, 1'b0, 8'h43, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 8'h09, 5'b10101, 1'b1, 3'd3, 3'd0, 1'b1, 3'd3, 3'd3, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h09, 5'b10101, 1'b1, 3'd1, 3'd0, 1'b1, 3'd1, 3'd0, 1'b0, 8'hA9, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 8'h03, 5'b00110, 1'b1, 3'd5, 3'd3, 1'b1, 3'd5, 3'd0, 1'b0, 8'h35, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 8'h03, 5'b00110, 1'b1, 3'd5, 3'd0, 1'b0, 3'd5, 3'd0, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'h09, 5'b10101, 1'b0, 3'd3, 3'd0, 1'b0, 3'd3, 3'd0, 1'b0, 8'hAF, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 8'h09, 5'b11111, 1'b1, 3'd0, 3'd0, 1'b1, 3'd0, 3'd0, 1'b1, 8'h00, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 8'hFF, 5'b00001, 1'b0, 3'd2, 3'd0, 1'b0, 3'd2, 3'd0, 1'b0, 8'h0F, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 8'h06, 5'b01010, 1'b0, 3'd4, 3'd6, 1'b0, 3'd4, 3'd0, 1'b0, 8'h57, 1'b1};

    // Reset state, with inputs that would otherwise produce activity.
    rst_n  = 1'b0;
    inta_n = 1'b1;
    set_cfg(vecs[0]);
    #3;
    chk("reset_async", 17'h0);
    repeat (2) cyc(1'b0);
    chk("reset_held", 17'h0);
    @(negedge clk);
    inta_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < int'(NVEC); i++) begin
      run_vec(i, vecs[i]);
    end

    // One-cycle-low pulses still pass through ACK1 and ACK2.
    @(negedge clk);
    set_cfg(vecs[0]);
    cyc(1'b1);
    cyc(1'b0);
    chk("short_t1", 17'h0);
    cyc(1'b1);
    chk("short_t2_isr", pk(3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd3));
    cyc(1'b0);
    chk("short_t3_gap", pk(3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3));
    cyc(1'b1);
    chk("short_t4_vec", pk(3'd0, 1'b0, 8'h43, 1'b1, 1'b0, 3'd3));
    cyc(1'b1);
    chk("short_t5_idle", 17'h0);

    // Master cascade: level change during GAP, then reset inside ACK2.
    @(negedge clk);
    set_cfg(vecs[1]);
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);
    chk("casc_ack1", pk(3'd3, 1'b1, 8'h00, 1'b0, 1'b1, 3'd3));
    cyc(1'b1);
    int_level = 3'd6;
    int_req   = 1'b0;
    cyc(1'b1);
    chk("casc_gap_hold", pk(3'd3, 1'b1, 8'h00, 1'b0, 1'b0, 3'd3));
    cyc(1'b0);
    cyc(1'b0);
    chk("casc_ack2", pk(3'd3, 1'b1, 8'h00, 1'b0, 1'b0, 3'd3));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("casc_rst_immediate", 17'h0);
    inta_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(100, vecs[1]);
    run_vec(101, vecs[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
